// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 host master. It sends one header word followed
// by NUM_WORDS payload words as 16-bit MSB-first slots and captures the
// returned result from miso.
// Optional build macro: SPI_MASTER_LOOPBACK_EN. When it is defined, the
// serial input is taken from the internal mosi instead of miso, for self-test.
module spi_frame_master #(
    parameter int          DATA_W    = 14,
    parameter int          NUM_WORDS = 5,
    parameter logic [15:0] HEAD_WORD = 16'hA5A5,
    parameter int          CLK_DIV   = 4,
    parameter int          CS_GAP    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_WORDS*DATA_W-1:0] tx_data,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        cs,
    output logic                        sck,
    output logic                        mosi,
    input  logic                        miso
);
    localparam int TOTAL = 16 * (NUM_WORDS + 1);
    localparam int BIT_W = $clog2(TOTAL);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t              state_q;
    logic [TOTAL-2:0]    sr_q;       // bits still to be sent after the current mosi bit
    logic [BIT_W-1:0]    bit_q;      // index of the bit currently on mosi
    logic [7:0]          div_q;      // cycle counter within a phase, HOLD or GAP
    logic [DATA_W-1:0]   rx_sr_q;    // most recent DATA_W sampled serial bits
    logic                cs_q, sck_q, mosi_q, busy_q, done_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic [TOTAL-1:0]    frame_d;
    logic                sin;

    // Assemble the full frame: the header word, then each payload word zero-padded to 16 bits.
    always_comb begin
        frame_d = '0;
        frame_d[TOTAL-1 -: 16] = HEAD_WORD;
        for (int k = 0; k < NUM_WORDS; k++) begin
            frame_d[(NUM_WORDS-k)*16-1 -: 16] =
                {{(16-DATA_W){1'b0}}, tx_data[(NUM_WORDS-k)*DATA_W-1 -: DATA_W]};
        end
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sin = mosi_q;
`else
    assign sin = miso;
`endif

    // Frame sequencer. All bus outputs are registered so that they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            rx_sr_q   <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    bit_q <= '0;
                    if (start) begin
                        sr_q    <= frame_d[TOTAL-2:0];
                        mosi_q  <= frame_d[TOTAL-1];
                        cs_q    <= 1'b0;
                        sck_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div_q == 8'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sck_q) begin
                            // The rising edge of sck is also the sampling point.
                            sck_q   <= 1'b1;
                            rx_sr_q <= {rx_sr_q[DATA_W-2:0], sin};
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == BIT_W'(TOTAL - 1)) begin
                                state_q <= S_HOLD;  // mosi keeps the last bit
                            end else begin
                                bit_q  <= bit_q + 1'b1;
                                mosi_q <= sr_q[TOTAL-2];
                                sr_q   <= {sr_q[TOTAL-3:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (div_q == 8'(CLK_DIV - 1)) begin
                        div_q     <= '0;
                        cs_q      <= 1'b1;
                        mosi_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sr_q;
                        state_q   <= S_GAP;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (div_q == 8'(CS_GAP - 1)) begin
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cs      = cs_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_frame_master.sv
// Testbench for spi_frame_master. A bus monitor decodes mosi at each sck rise
// and a slave model drives miso from a per-frame bit pattern. The reference
// model builds the expected word stream and the expected result from the
// frame rules directly.
module tb_spi_frame_master;
    localparam int DATA_W  = 14;
    localparam int NW      = 5;
    localparam int TOTAL   = 16 * (NW + 1);
    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 8;
    localparam int CS_LOW  = 2 * CLK_DIV * TOTAL + CLK_DIV;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [NW*DATA_W-1:0]   tx_data = '0;
    logic                   miso = 1'b0;
    logic                   busy, done, cs, sck, mosi;
    logic [DATA_W-1:0]      rx_data;

    spi_frame_master #(
        .DATA_W(DATA_W), .NUM_WORDS(NW), .HEAD_WORD(16'hA5A5),
        .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and slave model.
    logic [TOTAL-1:0]  miso_frame = '0;
    int                rise_cnt = 0, cs_low_cnt = 0, done_cnt = 0, bad_edge = 0;
    logic              prev_sck = 1'b0;
    logic [15:0]       shift_w = '0;
    logic [15:0]       got_q[$];
    logic [15:0]       exp_q[$];
    logic [DATA_W-1:0] rx_at_done = '0;

    always @(negedge clk) begin
        if (cs === 1'b0) cs_low_cnt++;
        if (sck !== prev_sck && cs !== 1'b0) bad_edge++;
        if (sck === 1'b1 && prev_sck === 1'b0) begin
            shift_w = {shift_w[14:0], mosi};
            rise_cnt++;
            if (rise_cnt % 16 == 0) got_q.push_back(shift_w);
        end
        if (done === 1'b1) begin
            done_cnt++;
            rx_at_done = rx_data;
        end
        prev_sck = sck;
        miso = (rise_cnt < TOTAL) ? miso_frame[TOTAL-1-rise_cnt] : 1'b0;
    end

    // Reference model: the value rx_data must take at the end of the frame.
    function automatic logic [DATA_W-1:0] model_rx(input logic [NW*DATA_W-1:0] tx,
                                                   input logic [TOTAL-1:0] mf);
`ifdef SPI_MASTER_LOOPBACK_EN
        model_rx = tx[DATA_W-1:0];
`else
        model_rx = mf[DATA_W-1:0];
`endif
    endfunction

    task automatic launch(input logic [NW*DATA_W-1:0] tx, input logic [TOTAL-1:0] mf,
                          input bit now);
        exp_q.delete();
        exp_q.push_back(16'hA5A5);
        for (int k = 0; k < NW; k++)
            exp_q.push_back({2'b00, tx[(NW-k)*DATA_W-1 -: DATA_W]});
        rise_cnt = 0; cs_low_cnt = 0; done_cnt = 0; bad_edge = 0;
        shift_w = '0;
        got_q.delete();
        miso_frame = mf;
        if (!now) @(negedge clk);
        start = 1'b1;
        tx_data = tx;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic [DATA_W-1:0] exp_rx,
                                input bit poke_gap);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        check({tag, "_done_seen"}, done_cnt > 0, 1);
        if (poke_gap) begin
            start = 1'b1;
            tx_data = '1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_word_cnt"}, got_q.size(), 6);
        for (int w = 0; w < 6 && got_q.size() > 0 && exp_q.size() > 0; w++)
            check($sformatf("%s_word%0d", tag, w), got_q.pop_front(), exp_q.pop_front());
        check({tag, "_cs_low"}, cs_low_cnt, CS_LOW);
        check({tag, "_rises"}, rise_cnt, TOTAL);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_rx"}, rx_at_done, exp_rx);
        check({tag, "_bad_edge"}, bad_edge, 0);
    endtask

    logic [NW*DATA_W-1:0] tx_v;
    logic [TOTAL-1:0]     mf_v;
    int                   viol;

    initial begin
        // Reset state, then 50 idle cycles.
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_outs", {mosi, busy, done}, 0);
        check("rst_rx", rx_data, 0);
        rst = 1'b0;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || rx_data !== '0) viol++;
        end
        check("idle_50", viol, 0);

        // Directed frame, miso held at 0.
        tx_v = {14'h0001, 14'h0002, 14'h0003, 14'h0004, 14'h3FFF};
        launch(tx_v, '0, 0);
        finish_frame("dir0", model_rx(tx_v, '0), 0);

        // The slave returns 16'h2ABC in the final slot.
        mf_v = '0;
        mf_v[15:0] = 16'h2ABC;
        launch(tx_v, mf_v, 0);
        finish_frame("slave", model_rx(tx_v, mf_v), 0);
        repeat (50) @(negedge clk);
        check("rx_hold_idle", rx_data, model_rx(tx_v, mf_v));
        launch(tx_v, '1, 0);
        repeat (100) @(negedge clk);
        check("rx_hold_frame", rx_data, model_rx(tx_v, mf_v));
        finish_frame("ones", model_rx(tx_v, '1), 0);

        // Last word 14'h1234 with miso tied high.
        tx_v = {14'h0AAA, 14'h1555, 14'h0F0F, 14'h30C3, 14'h1234};
        launch(tx_v, '1, 0);
        finish_frame("lb", model_rx(tx_v, '1), 0);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            tx_v = {$urandom, $urandom, $urandom};
            mf_v = {$urandom, $urandom, $urandom};
            launch(tx_v, mf_v, 0);
            finish_frame($sformatf("rnd%0d", r), model_rx(tx_v, mf_v), 0);
        end

        // start pulses mid-frame and during GAP must be ignored.
        tx_v = {$urandom, $urandom, $urandom};
        launch(tx_v, '0, 0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        tx_data = ~tx_v;
        @(negedge clk);
        start = 1'b0;
        finish_frame("ign", model_rx(tx_v, '0), 1);
        repeat (30) @(negedge clk);
        check("ign_single_done", done_cnt, 1);
        check("ign_cs_high", cs_low_cnt, CS_LOW);

        // start in the first IDLE cycle after busy falls.
        tx_v = {$urandom, $urandom, $urandom};
        launch(tx_v, '0, 0);
        finish_frame("back0", model_rx(tx_v, '0), 0);
        tx_v = {$urandom, $urandom, $urandom};
        mf_v = {$urandom, $urandom, $urandom};
        launch(tx_v, mf_v, 1);
        check("first_idle_cs", cs, 0);
        finish_frame("back1", model_rx(tx_v, mf_v), 0);

        // Reset at sck rise 40 aborts the frame.
        tx_v = {$urandom, $urandom, $urandom};
        launch(tx_v, '0, 0);
        for (int i = 0; i < 2000 && rise_cnt < 40; i++) @(negedge clk);
        check("rst_mid_reach40", rise_cnt, 40);
        rst = 1'b1;
        #1;
        check("rst_mid_cs", cs, 1);
        check("rst_mid_sck", sck, 0);
        check("rst_mid_busy", busy, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_no_done", done_cnt, 0);
        tx_v = {$urandom, $urandom, $urandom};
        mf_v = {$urandom, $urandom, $urandom};
        launch(tx_v, mf_v, 0);
        finish_frame("post_rst", model_rx(tx_v, mf_v), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
